alu_vec_recorder: RTL and testbench
===================================

Name: alu_vec_recorder

Overview:
Capture-side counterpart to the 74181 vector-file reader. Samples live alu74181 operand/control/result tuples and packs each into a 19-bit test-vector record using the same bit layout as the vector files. Records are buffered in a FIFO and streamed out on a valid/ready port to a host, UART, or memory writer. This lets real ALU traffic be logged as replayable vector files.

Parameters:
DEPTH, 16, FIFO depth in records; power of two, 2 to 256.
CNT_W, 16, width of the accepted-record counter.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  one-cycle pulse; begins a capture session.
stop  input  1  one-cycle pulse; ends capture and drains the FIFO.
cap_valid  input  1  sample strobe; current ALU tuple is valid.
s  input  4  ALU function select.
M  input  1  ALU mode.
ci  input  1  ALU carry-in.
a  input  4  operand A.
b  input  4  operand B.
y  input  4  ALU result.
out_valid  output  1  out_data holds a record.
out_ready  input  1  consumer accepts the record.
out_data  output  19  record {1'b0, s, M, ci, a, b, y}; bit 18 is always 0.
out_last  output  1  final record of the session; qualified by out_valid.
busy  output  1  state is CAPTURE or DRAIN.
done  output  1  state is DONE.
overflow  output  1  sticky; at least one sample was dropped this session.
drop_cnt  output  8  dropped samples; saturates at 255.
rec_count  output  CNT_W  accepted samples; saturates at all-ones.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; FIFO is emptied.
  - All outputs are 0: out_valid, out_last, out_data, busy, done, overflow, drop_cnt, rec_count.
- FSM has four states: IDLE, CAPTURE, DRAIN, DONE.
  - IDLE: start moves to CAPTURE. stop is ignored.
  - CAPTURE: stop moves to DRAIN. start is ignored.
  - DRAIN: moves to DONE on the cycle the last FIFO record is handshaken out, or on the next cycle if the FIFO is already empty.
  - DONE: start moves to CAPTURE.
  - start and stop in the same cycle: only the transition legal for the current state occurs.
- Entering CAPTURE on a start pulse:
  - FIFO is flushed; overflow, drop_cnt and rec_count clear to 0.
  - done drops the next cycle.
  - A cap_valid in the start cycle itself is not captured.
- Push rule:
  - Push occurs when state is CAPTURE, cap_valid=1 and the FIFO is not full.
  - Fullness is evaluated before any same-cycle pop, so a full FIFO rejects a push even while popping.
  - Each push increments rec_count.
  - A cap_valid in CAPTURE with a full FIFO is a drop: overflow sets, drop_cnt increments (saturating).
  - cap_valid in the stop cycle is still captured. cap_valid in DRAIN, DONE or IDLE is ignored and is not counted as a drop.
- Output port:
  - Registered FIFO head; latency is 1 cycle from push into an empty FIFO to out_valid=1.
  - No combinational input-to-output path.
  - A pop occurs when out_valid and out_ready are both 1.
  - While out_valid=1 and out_ready=0, out_data and out_last are held stable.
  - out_valid never drops without a handshake, except on reset.
- out_last:
  - Asserted with a record only when state is DRAIN and that record is the sole FIFO entry.
  - Not asserted during CAPTURE, even if the FIFO briefly empties.
  - A session with zero records emits no out_last.
- Pointers wrap modulo DEPTH. Occupancy needs a log2(DEPTH)+1 bit count so full and empty are distinguishable.
- Saturation:
  - rec_count holds at 2^CNT_W-1.
  - drop_cnt holds at 255; overflow stays set.
- Reset mid-session abandons all buffered records. No out_last is produced.

Test Plan:
- Basic capture:
  - Stimulus: reset, start, one sample s=1001 M=0 ci=1 a=0011 b=0101 y=1001, then stop with out_ready=1.
  - Required: out_data=0_1001_0_1_0011_0101_1001, out_valid 1 cycle after the push, out_last=1, rec_count=1, then done=1.
- Backpressure:
  - Stimulus: capture 3 samples with out_ready=0 for 10 cycles, then raise out_ready.
  - Required: first record held stable throughout the stall; records emerge in order; drop_cnt=0.
- Overflow:
  - Stimulus: out_ready=0, DEPTH=16, 20 consecutive cap_valid.
  - Required: rec_count=16, drop_cnt=4, overflow=1. Draining gives exactly 16 records, the first 16 in order, with out_last on the 16th.
- Drop boundary:
  - Stimulus: FIFO full, out_ready=1 and cap_valid=1 in the same cycle.
  - Required: the sample is dropped and drop_cnt increments; the next cycle's sample is accepted.
- Empty session:
  - Stimulus: start, then stop with no samples.
  - Required: out_valid never asserts; done=1 two cycles after stop; rec_count=0.
- Reset and restart:
  - Stimulus: assert reset with 5 records buffered, release, start again.
  - Required: all outputs 0 immediately on reset; the new session's first record is the first new sample; no stale data appears.

Source files
------------

// File: rtl/alu_vec_recorder.sv
// Packs live 74181 operand/control/result tuples into 19-bit vector records and streams them out.
// One cycle from push to out_valid; a stalled consumer fills the FIFO, then further samples are dropped and counted.
module alu_vec_recorder #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             cap_valid,
    input  logic [3:0]       s,
    input  logic             M,
    input  logic             ci,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic [3:0]       y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [18:0]      out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [7:0]       drop_cnt,
    output logic [CNT_W-1:0] rec_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [17:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic [17:0]   sample;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;
    logic          flush;
    logic          head_from_sample;

    assign sample  = {s, M, ci, a, b, y};
    assign full    = (count == FULL_CNT);
    assign pop     = out_valid && out_ready;
    assign push    = (state == CAPTURE) && cap_valid && !full;
    assign drop    = (state == CAPTURE) && cap_valid && full;
    assign flush   = start && ((state == IDLE) || (state == DONE));
    assign rd_next = pop ? rd_ptr + AW'(1) : rd_ptr;

    // The incoming sample becomes the head when nothing else remains after this cycle's pop.
    assign head_from_sample = push && (count == {{AW{1'b0}}, pop});

    always_comb begin
        count_next = count;
        if (push) begin
            count_next = count_next + ONE_CNT;
        end
        if (pop) begin
            count_next = count_next - ONE_CNT;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CAPTURE;
            CAPTURE: if (stop)  state_next = DRAIN;
            DRAIN:   if ((count == '0) || (pop && (count == ONE_CNT))) state_next = DONE;
            DONE:    if (start) state_next = CAPTURE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
            rec_count <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next == CAPTURE) || (state_next == DRAIN);
            done  <= (state_next == DONE);
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                overflow  <= 1'b0;
                drop_cnt  <= '0;
                rec_count <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                rd_ptr    <= rd_next;
                count     <= count_next;
                out_valid <= (count_next != '0);
                // Only a record that is alone in the buffer while draining can be the session's last.
                out_last  <= (state_next == DRAIN) && (count_next == ONE_CNT);
                if (head_from_sample) begin
                    out_data <= {1'b0, sample};
                end else if (count_next != '0) begin
                    out_data <= {1'b0, mem[rd_next]};
                end
                if (push && (rec_count != '1)) begin
                    rec_count <= rec_count + CNT_W'(1);
                end
                if (drop) begin
                    overflow <= 1'b1;
                    if (drop_cnt != 8'hFF) begin
                        drop_cnt <= drop_cnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_vec_recorder.sv
// Directed and randomized sessions against a queue-based model of the recorder.
module tb_alu_vec_recorder;

    localparam int DEPTH   = 16;
    localparam int CNT_W   = 16;
    localparam int S_IDLE  = 0;
    localparam int S_CAP   = 1;
    localparam int S_DRAIN = 2;
    localparam int S_DONE  = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             stop;
    logic             cap_valid;
    logic [3:0]       s;
    logic             M;
    logic             ci;
    logic [3:0]       a;
    logic [3:0]       b;
    logic [3:0]       y;
    logic             out_valid;
    logic             out_ready;
    logic [18:0]      out_data;
    logic             out_last;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [7:0]       drop_cnt;
    logic [CNT_W-1:0] rec_count;

    alu_vec_recorder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .cap_valid(cap_valid),
        .s(s), .M(M), .ci(ci), .a(a), .b(b), .y(y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .overflow(overflow), .drop_cnt(drop_cnt), .rec_count(rec_count)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [18:0] mq[$];
    int          mode;
    int          m_rec;
    int          m_drop;
    int          m_ovf;
    int          n_pops;
    int          last_at;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] rnd();
        return 18'($urandom);
    endfunction

    task automatic check_outs();
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
        chk("out_last", 32'(out_last), 32'((mode == S_DRAIN) && (mq.size() == 1)));
        chk("busy", 32'(busy), 32'((mode == S_CAP) || (mode == S_DRAIN)));
        chk("done", 32'(done), 32'(mode == S_DONE));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("rec_count", 32'(rec_count), 32'(m_rec));
    endtask

    task automatic model_step(input logic st, input logic sp, input logic cv, input logic rdy,
                              input logic [17:0] tup);
        int sz;
        int nmode;
        bit popm;
        sz    = mq.size();
        popm  = (sz != 0) && rdy;
        nmode = mode;
        case (mode)
            S_IDLE, S_DONE: if (st) nmode = S_CAP;
            S_CAP:          if (sp) nmode = S_DRAIN;
            S_DRAIN:        if ((sz == 0) || (popm && (sz == 1))) nmode = S_DONE;
            default:        nmode = S_IDLE;
        endcase
        if (st && ((mode == S_IDLE) || (mode == S_DONE))) begin
            mq.delete();
            m_rec  = 0;
            m_drop = 0;
            m_ovf  = 0;
        end else begin
            if (popm) void'(mq.pop_front());
            if ((mode == S_CAP) && cv) begin
                if (sz < DEPTH) begin
                    mq.push_back({1'b0, tup});
                    if (m_rec < 65535) m_rec++;
                end else begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
        mode = nmode;
    endtask

    // Called at a falling edge: check, drive this cycle's inputs, advance one clock.
    task automatic cyc(input logic st, input logic sp, input logic cv, input logic rdy,
                       input logic [17:0] tup);
        check_outs();
        start     = st;
        stop      = sp;
        cap_valid = cv;
        out_ready = rdy;
        {s, M, ci, a, b, y} = tup;
        if (out_valid && rdy) begin
            n_pops++;
            if (out_last) last_at = n_pops;
        end
        model_step(st, sp, cv, rdy, tup);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; (i < DEPTH + 8) && (mode != S_DONE); i++) begin
            cyc(1'b0, 1'b0, 1'($urandom % 2), 1'b1, rnd());
        end
        chk("drain_done", 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        start     = 1'b0;
        stop      = 1'b0;
        cap_valid = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_rec_count", 32'(rec_count), 32'd0);
        mq.delete();
        mode   = S_IDLE;
        m_rec  = 0;
        m_drop = 0;
        m_ovf  = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [17:0] t0;
        logic [17:0] basic;
        reset = 1'b1; start = 1'b0; stop = 1'b0; cap_valid = 1'b0; out_ready = 1'b0;
        {s, M, ci, a, b, y} = '0;
        mode = S_IDLE; m_rec = 0; m_drop = 0; m_ovf = 0; n_pops = 0; last_at = 0;
        @(negedge clk);
        do_reset();

        // Idle ignores stop and samples.
        cyc(1'b0, 1'b1, 1'b1, 1'b1, rnd());
        cyc(1'b0, 1'b0, 1'b1, 1'b1, rnd());

        // Basic capture: the sample lands in the stop cycle, start-cycle sample is not captured.
        basic = {4'b1001, 1'b0, 1'b1, 4'b0011, 4'b0101, 4'b1001};
        cyc(1'b1, 1'b0, 1'b1, 1'b1, rnd());
        cyc(1'b0, 1'b1, 1'b1, 1'b1, basic);
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_data", 32'(out_data), 32'h25359);
        chk("basic_last", 32'(out_last), 32'd1);
        chk("basic_rec", 32'(rec_count), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, rnd());
        chk("basic_done", 32'(done), 32'd1);

        // Backpressure: three records held through a ten-cycle stall.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, rnd());
        t0 = rnd();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, t0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd());
        cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd());
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", 32'(out_data), 32'({1'b0, t0}));
            cyc(1'b0, 1'b0, 1'b0, 1'b0, rnd());
        end
        chk("bp_drop", 32'(drop_cnt), 32'd0);
        n_pops = 0; last_at = 0;
        cyc(1'b0, 1'b1, 1'b0, 1'b1, rnd());
        drain();
        chk("bp_pops", 32'(n_pops), 32'd3);
        chk("bp_last_at", 32'(last_at), 32'd3);

        // Overflow: twenty samples into a stalled sixteen-entry buffer.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, rnd());
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd());
        chk("ovf_rec", 32'(rec_count), 32'd16);
        chk("ovf_drop", 32'(drop_cnt), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        n_pops = 0; last_at = 0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, rnd());
        drain();
        chk("ovf_pops", 32'(n_pops), 32'd16);
        chk("ovf_last_at", 32'(last_at), 32'd16);

        // Drop boundary: full buffer popping in the same cycle still rejects the sample.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, rnd());
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd());
        cyc(1'b0, 1'b0, 1'b1, 1'b1, rnd());
        chk("db_drop", 32'(drop_cnt), 32'd1);
        chk("db_rec", 32'(rec_count), 32'd16);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd());
        chk("db_next_rec", 32'(rec_count), 32'd17);
        chk("db_next_drop", 32'(drop_cnt), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, rnd());
        drain();

        // Empty session: done two cycles after stop, nothing emitted.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, rnd());
        cyc(1'b0, 1'b1, 1'b0, 1'b1, rnd());
        chk("es_done1", 32'(done), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, rnd());
        chk("es_done2", 32'(done), 32'd1);
        chk("es_rec", 32'(rec_count), 32'd0);
        chk("es_valid", 32'(out_valid), 32'd0);

        // Start and stop together from DONE only starts; random traffic with stray starts.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, rnd());
        for (int i = 0; i < 300; i++) begin
            cyc(1'(($urandom % 40) == 0), 1'b0, 1'($urandom % 2), 1'(($urandom % 3) != 0), rnd());
        end
        cyc(1'b0, 1'b1, 1'($urandom % 2), 1'($urandom % 2), rnd());
        drain();

        // Drop counter saturation.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, rnd());
        for (int i = 0; i < DEPTH + 260; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd());
        chk("sat_drop", 32'(drop_cnt), 32'd255);
        chk("sat_ovf", 32'(overflow), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, rnd());
        drain();

        // Reset mid-session discards buffered records; the restart sees only new samples.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, rnd());
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd());
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, rnd());
        t0 = rnd();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, t0);
        chk("rr_valid", 32'(out_valid), 32'd1);
        chk("rr_first", 32'(out_data), 32'({1'b0, t0}));
        chk("rr_rec", 32'(rec_count), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd());
        n_pops = 0; last_at = 0;
        cyc(1'b0, 1'b1, 1'b0, 1'b1, rnd());
        drain();
        chk("rr_pops", 32'(n_pops), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
